// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: per-entry control struct, null tag and pointer wrap helper.
// Tags run 1..DEPTH; tag 0 means "no tag / value ready".
package rob_pkg;

   localparam int ROB_TAG_NULL = 0;

   typedef struct packed {
      logic       valid;
      logic       ready;
      logic       wen;
      logic       is_branch;
      logic       pred;
      logic       taken;
      logic [4:0] rd;
   } rob_ent_t;

   function automatic int unsigned next_tag(input int unsigned tag, input int unsigned depth);
      return (tag >= depth) ? 32'd1 : tag + 32'd1;
   endfunction

endpackage

// File: rtl/rob_read_port.sv
// Operand lookup by tag, combinational; tag 0 always reads as ready with zero data.
// With ROB_RP_CDB_BYPASS_EN defined, a same-cycle CDB hit overrides stored state (lowest channel wins).
module rob_read_port #(
   parameter int DEPTH   = 16,
   parameter int NUM_CDB = 2,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = $clog2(DEPTH+1)
) (
   input  logic [TAG_W-1:0]          rp_tag,
   input  logic [DEPTH-1:0]          ent_ready,
   input  logic [DEPTH*DATA_W-1:0]   ent_data,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
   input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
   output logic [DATA_W-1:0]         rp_data,
   output logic                      rp_ready
);
   import rob_pkg::*;

   always_comb begin
      rp_ready = 1'b0;
      rp_data  = '0;
      if (rp_tag == TAG_W'(ROB_TAG_NULL)) begin
         rp_ready = 1'b1;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rp_tag == TAG_W'(i+1)) begin
               rp_ready = ent_ready[i];
               rp_data  = ent_data[i*DATA_W +: DATA_W];
            end
         end
`ifdef ROB_RP_CDB_BYPASS_EN
         // Descending scan so the lowest-index channel is applied last and wins.
         for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (cdb_tag[c*TAG_W +: TAG_W] == rp_tag) begin
               rp_ready = 1'b1;
               rp_data  = cdb_data[c*DATA_W +: DATA_W];
            end
         end
`endif
      end
   end

`ifndef ROB_RP_CDB_BYPASS_EN
   logic unused_cdb;
   assign unused_cdb = ^{cdb_tag, cdb_data};
`endif

endmodule

// File: rtl/rob_nway.sv
// Parametrised ROB: in-order registered commit (1/cycle), mispredict flush, two operand read ports.
// alloc_ready = !full && !flush; CDB-to-commit is two edges minimum. Optional macro: ROB_RP_CDB_BYPASS_EN.
module rob_nway #(
   parameter int DEPTH   = 16,
   parameter int NUM_CDB = 2,
   parameter int DATA_W  = 32,
   parameter int OPC_W   = 12,
   parameter int TAG_W   = $clog2(DEPTH+1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_valid,
   input  logic [OPC_W-1:0]             alloc_opcode,
   input  logic [4:0]                   alloc_rd,
   input  logic                         alloc_wen,
   input  logic                         alloc_is_branch,
   input  logic                         alloc_pred_taken,
   input  logic [DATA_W-1:0]            alloc_alt_target,
   output logic                         alloc_ready,
   output logic [TAG_W-1:0]             alloc_tag,
   input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
   input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
   input  logic [NUM_CDB-1:0]           cdb_taken,
   input  logic [TAG_W-1:0]             rp_tag1,
   input  logic [TAG_W-1:0]             rp_tag2,
   output logic [DATA_W-1:0]            rp_data1,
   output logic [DATA_W-1:0]            rp_data2,
   output logic                         rp_ready1,
   output logic                         rp_ready2,
   output logic                         commit_valid,
   output logic [OPC_W-1:0]             commit_opcode,
   output logic [4:0]                   commit_rd,
   output logic                         commit_wen,
   output logic [DATA_W-1:0]            commit_data,
   output logic [TAG_W-1:0]             commit_tag,
   output logic                         flush,
   output logic [DATA_W-1:0]            flush_target,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   import rob_pkg::*;

   localparam int CNT_W = $clog2(DEPTH+1);

   rob_ent_t          ent      [DEPTH];
   logic [OPC_W-1:0]  ent_opc  [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [DATA_W-1:0] ent_alt  [DEPTH];
   logic [TAG_W-1:0]  head, tail;

   rob_ent_t          head_ent;
   logic [OPC_W-1:0]  head_opc;
   logic [DATA_W-1:0] head_data, head_alt;
   logic              accept, do_commit, mispredict;
   logic [DEPTH-1:0]  wb_hit, wb_taken;
   logic [DATA_W-1:0] wb_data  [DEPTH];
   logic [DEPTH-1:0]  rdy_flat;
   logic [DEPTH*DATA_W-1:0] data_flat;

   assign full        = (count == CNT_W'(DEPTH));
   assign empty       = (count == '0);
   assign alloc_ready = !full && !flush;
   assign alloc_tag   = tail;
   assign accept      = alloc_valid && alloc_ready;

   always_comb begin
      head_ent  = '0;
      head_opc  = '0;
      head_data = '0;
      head_alt  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (head == TAG_W'(i+1)) begin
            head_ent  = ent[i];
            head_opc  = ent_opc[i];
            head_data = ent_data[i];
            head_alt  = ent_alt[i];
         end
      end
      do_commit  = head_ent.valid && head_ent.ready;
      mispredict = do_commit && head_ent.is_branch && (head_ent.taken != head_ent.pred);
   end

   // Per-entry write-back select; descending channel scan lets channel 0 win on a shared tag.
   always_comb begin
      wb_hit   = '0;
      wb_taken = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wb_data[i] = '0;
         for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (cdb_tag[c*TAG_W +: TAG_W] == TAG_W'(i+1)) begin
               wb_hit[i]   = ent[i].valid;
               wb_taken[i] = cdb_taken[c];
               wb_data[i]  = cdb_data[c*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent[i]      <= '0;
            ent_opc[i]  <= '0;
            ent_data[i] <= '0;
            ent_alt[i]  <= '0;
         end
         head          <= TAG_W'(1);
         tail          <= TAG_W'(1);
         count         <= '0;
         commit_valid  <= 1'b0;
         commit_opcode <= '0;
         commit_rd     <= '0;
         commit_wen    <= 1'b0;
         commit_data   <= '0;
         commit_tag    <= '0;
         flush         <= 1'b0;
         flush_target  <= '0;
      end else begin
         commit_valid <= 1'b0;
         flush        <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (wb_hit[i]) begin
               ent[i].ready <= 1'b1;
               ent[i].taken <= wb_taken[i];
               ent_data[i]  <= wb_data[i];
            end
         end
         if (do_commit) begin
            commit_valid  <= 1'b1;
            commit_opcode <= head_opc;
            commit_rd     <= head_ent.rd;
            commit_wen    <= head_ent.wen;
            commit_data   <= head_data;
            commit_tag    <= head;
            for (int i = 0; i < DEPTH; i++)
               if (head == TAG_W'(i+1)) ent[i].valid <= 1'b0;
            head <= TAG_W'(next_tag(32'(head), DEPTH));
         end
         if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (tail == TAG_W'(i+1)) begin
                  ent[i]     <= '{valid: 1'b1, ready: 1'b0, wen: alloc_wen,
                                  is_branch: alloc_is_branch, pred: alloc_pred_taken,
                                  taken: 1'b0, rd: alloc_rd};
                  ent_opc[i] <= alloc_opcode;
                  ent_alt[i] <= alloc_alt_target;
               end
            end
            tail <= TAG_W'(next_tag(32'(tail), DEPTH));
         end
         count <= count + CNT_W'(accept) - CNT_W'(do_commit);
         // Squash overrides everything above, including any allocation this cycle.
         if (mispredict) begin
            flush        <= 1'b1;
            flush_target <= head_alt;
            for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
            head  <= TAG_W'(1);
            tail  <= TAG_W'(1);
            count <= '0;
         end
      end
   end

   always_comb begin
      rdy_flat  = '0;
      data_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rdy_flat[i]                    = ent[i].ready;
         data_flat[i*DATA_W +: DATA_W]  = ent_data[i];
      end
   end

   rob_read_port #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_rp1 (
      .rp_tag(rp_tag1), .ent_ready(rdy_flat), .ent_data(data_flat),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .rp_data(rp_data1), .rp_ready(rp_ready1)
   );

   rob_read_port #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_rp2 (
      .rp_tag(rp_tag2), .ent_ready(rdy_flat), .ent_data(data_flat),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .rp_data(rp_data2), .rp_ready(rp_ready2)
   );

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway: table of per-cycle vectors for in-order commit, plus
// hand sequences for full/wrap, mispredict flush, dual-CDB priority, read bypass and async reset.
module tb_rob_nway;

   localparam int DEPTH = 16, NUM_CDB = 2, DATA_W = 32, OPC_W = 12, TAG_W = 5;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      alloc_valid;
   logic [OPC_W-1:0]          alloc_opcode;
   logic [4:0]                alloc_rd;
   logic                      alloc_wen, alloc_is_branch, alloc_pred_taken;
   logic [DATA_W-1:0]         alloc_alt_target;
   logic                      alloc_ready;
   logic [TAG_W-1:0]          alloc_tag;
   logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
   logic [NUM_CDB*DATA_W-1:0] cdb_data;
   logic [NUM_CDB-1:0]        cdb_taken;
   logic [TAG_W-1:0]          rp_tag1, rp_tag2;
   logic [DATA_W-1:0]         rp_data1, rp_data2;
   logic                      rp_ready1, rp_ready2;
   logic                      commit_valid, commit_wen, flush, full, empty;
   logic [OPC_W-1:0]          commit_opcode;
   logic [4:0]                commit_rd;
   logic [DATA_W-1:0]         commit_data, flush_target;
   logic [TAG_W-1:0]          commit_tag;
   logic [4:0]                count;

   int checks = 0;
   int failures = 0;

   rob_nway #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .OPC_W(OPC_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_opcode(alloc_opcode), .alloc_rd(alloc_rd),
      .alloc_wen(alloc_wen), .alloc_is_branch(alloc_is_branch), .alloc_pred_taken(alloc_pred_taken),
      .alloc_alt_target(alloc_alt_target), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_taken(cdb_taken),
      .rp_tag1(rp_tag1), .rp_tag2(rp_tag2), .rp_data1(rp_data1), .rp_data2(rp_data2),
      .rp_ready1(rp_ready1), .rp_ready2(rp_ready2),
      .commit_valid(commit_valid), .commit_opcode(commit_opcode), .commit_rd(commit_rd),
      .commit_wen(commit_wen), .commit_data(commit_data), .commit_tag(commit_tag),
      .flush(flush), .flush_target(flush_target), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             av;
      logic [TAG_W-1:0] t0;
      logic [31:0]      d0;
      logic [TAG_W-1:0] t1;
      logic [31:0]      d1;
      logic [TAG_W-1:0] exp_atag;
      logic             exp_cv;
      logic [TAG_W-1:0] exp_ctag;
      logic [31:0]      exp_cdata;
      logic [4:0]       exp_cnt;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 1'b0; alloc_opcode = '0; alloc_rd = '0; alloc_wen = 1'b0;
      alloc_is_branch = 1'b0; alloc_pred_taken = 1'b0; alloc_alt_target = '0;
      cdb_tag = '0; cdb_data = '0; cdb_taken = '0;
   endtask

   task automatic alloc(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] alt);
      idle();
      alloc_valid = 1'b1; alloc_opcode = 12'h0A0 + 12'(rd); alloc_rd = rd; alloc_wen = 1'b1;
      alloc_is_branch = br; alloc_pred_taken = pred; alloc_alt_target = alt;
      step();
      idle();
   endtask

   task automatic cdb0(input logic [TAG_W-1:0] t, input logic [31:0] d, input logic tk);
      idle();
      cdb_tag[0 +: TAG_W] = t; cdb_data[0 +: DATA_W] = d; cdb_taken[0] = tk;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      step();
      step();
      #2 rst = 1'b1;
      step();
   endtask

   function automatic vec_t mk(input logic av, input int t0, input int d0, input int t1, input int d1,
                               input int atag, input logic cv, input int ctag, input int cdata, input int cnt);
      vec_t v;
      v.av = av; v.t0 = TAG_W'(t0); v.d0 = 32'(d0); v.t1 = TAG_W'(t1); v.d1 = 32'(d1);
      v.exp_atag = TAG_W'(atag); v.exp_cv = cv; v.exp_ctag = TAG_W'(ctag);
      v.exp_cdata = 32'(cdata); v.exp_cnt = 5'(cnt);
      return v;
   endfunction

   initial begin
      rp_tag1 = '0; rp_tag2 = '0;
      rst = 1'b1;
      idle();

      // Reset state
      do_reset();
      chk("rst_count", 64'(count), 0);
      chk("rst_empty", 64'(empty), 1);
      chk("rst_full", 64'(full), 0);
      chk("rst_cv", 64'(commit_valid), 0);
      chk("rst_flush", 64'(flush), 0);
      chk("rst_ftgt", 64'(flush_target), 0);
      chk("rst_ctag", 64'(commit_tag), 0);
      chk("rst_aready", 64'(alloc_ready), 1);
      chk("rst_atag", 64'(alloc_tag), 1);
      chk("rp_null", 64'({rp_ready1, rp_data1}), 64'({1'b1, 32'h0}));

      // In-order commit with out-of-order results: av, t0,d0, t1,d1, atag, cv,ctag,cdata, count
      tbl[0] = mk(1, 0, 0,    0, 0,    1, 0, 0, 0,    1);
      tbl[1] = mk(1, 0, 0,    0, 0,    2, 0, 0, 0,    2);
      tbl[2] = mk(1, 0, 0,    0, 0,    3, 0, 0, 0,    3);
      tbl[3] = mk(0, 2, 'h55, 0, 0,    4, 0, 0, 0,    3);
      tbl[4] = mk(0, 1, 'h11, 0, 0,    4, 0, 0, 0,    3);
      tbl[5] = mk(0, 0, 0,    0, 0,    4, 1, 1, 'h11, 2);
      tbl[6] = mk(0, 0, 0,    3, 'h33, 4, 1, 2, 'h55, 1);
      tbl[7] = mk(0, 0, 0,    0, 0,    4, 1, 3, 'h33, 0);
      tbl[8] = mk(0, 0, 0,    0, 0,    4, 0, 0, 0,    0);
      for (int k = 0; k < 9; k++) begin
         idle();
         alloc_valid = tbl[k].av; alloc_rd = 5'(k + 1); alloc_wen = 1'b1;
         cdb_tag  = {tbl[k].t1, tbl[k].t0};
         cdb_data = {tbl[k].d1, tbl[k].d0};
         #1;
         chk($sformatf("tbl%0d_atag", k), 64'(alloc_tag), 64'(tbl[k].exp_atag));
         step();
         chk($sformatf("tbl%0d_cv", k), 64'(commit_valid), 64'(tbl[k].exp_cv));
         chk($sformatf("tbl%0d_cnt", k), 64'(count), 64'(tbl[k].exp_cnt));
         if (tbl[k].exp_cv) begin
            chk($sformatf("tbl%0d_ctag", k), 64'(commit_tag), 64'(tbl[k].exp_ctag));
            chk($sformatf("tbl%0d_cdata", k), 64'(commit_data), 64'(tbl[k].exp_cdata));
            chk($sformatf("tbl%0d_crd", k), 64'(commit_rd), 64'(tbl[k].exp_ctag));
         end
      end
      idle();

      // Full, refused allocation during commit, wrap of tail to tag 1
      do_reset();
      for (int i = 0; i < DEPTH; i++) alloc(5'(i), 1'b0, 1'b0, 32'h0);
      chk("full_flag", 64'(full), 1);
      chk("full_count", 64'(count), 16);
      chk("full_aready", 64'(alloc_ready), 0);
      chk("full_atag_wrap", 64'(alloc_tag), 1);
      cdb0(5'd1, 32'hC1, 1'b0);
      step();
      idle();
      alloc_valid = 1'b1;
      #1;
      chk("full_commit_aready", 64'(alloc_ready), 0);
      step();
      chk("full_commit_cv", 64'(commit_valid), 1);
      chk("full_commit_count", 64'(count), 15);
      chk("full_next_aready", 64'(alloc_ready), 1);
      chk("full_next_atag", 64'(alloc_tag), 1);
      step();
      idle();
      chk("refill_count", 64'(count), 16);
      chk("refill_full", 64'(full), 1);

      // Mispredicted branch at head with four younger entries
      do_reset();
      alloc(5'd1, 1'b1, 1'b0, 32'h40);
      for (int i = 0; i < 4; i++) alloc(5'(i + 2), 1'b0, 1'b0, 32'h0);
      cdb0(5'd1, 32'h0, 1'b1);
      step();
      idle();
      alloc_valid = 1'b1;
      step();
      idle();
      chk("mp_cv", 64'(commit_valid), 1);
      chk("mp_flush", 64'(flush), 1);
      chk("mp_ftgt", 64'(flush_target), 32'h40);
      chk("mp_count", 64'(count), 0);
      chk("mp_aready", 64'(alloc_ready), 0);
      chk("mp_atag", 64'(alloc_tag), 1);
      step();
      chk("mp_flush_pulse", 64'({flush, commit_valid}), 0);
      chk("mp_after_aready", 64'(alloc_ready), 1);

      // Two channels on the same tag; stray write to an unallocated tag
      do_reset();
      for (int i = 0; i < 5; i++) alloc(5'(i + 1), 1'b0, 1'b0, 32'h0);
      cdb_tag = {5'd5, 5'd5}; cdb_data = {32'hB, 32'hA};
      step();
      cdb0(5'd9, 32'hDEAD, 1'b0);
      rp_tag1 = 5'd5;
      rp_tag2 = 5'd9;
      step();
      idle();
      chk("dual_cdb_rdy", 64'(rp_ready1), 1);
      chk("dual_cdb_data", 64'(rp_data1), 32'hA);
      chk("stray_rdy", 64'(rp_ready2), 0);
      chk("stray_count", 64'(count), 5);

      // Read-port view of a CDB write in flight
      cdb0(5'd4, 32'h77, 1'b0);
      rp_tag1 = 5'd4;
      #1;
`ifdef ROB_RP_CDB_BYPASS_EN
      chk("rp_same_cycle", 64'({rp_ready1, rp_data1}), 64'({1'b1, 32'h77}));
`else
      chk("rp_same_cycle", 64'(rp_ready1), 0);
`endif
      step();
      idle();
      chk("rp_next_cycle", 64'({rp_ready1, rp_data1}), 64'({1'b1, 32'h77}));
      rp_tag1 = '0; rp_tag2 = '0;

      // Asynchronous reset with six entries held and the head about to commit
      do_reset();
      for (int i = 0; i < 6; i++) alloc(5'(i + 1), 1'b0, 1'b0, 32'h0);
      cdb0(5'd1, 32'h99, 1'b0);
      step();
      idle();
      #2 rst = 1'b0;
      #1;
      chk("arst_count", 64'(count), 0);
      chk("arst_empty", 64'(empty), 1);
      step();
      chk("arst_no_commit", 64'(commit_valid), 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_atag", 64'(alloc_tag), 1);
      alloc(5'd3, 1'b0, 1'b0, 32'h0);
      chk("arst_realloc_count", 64'(count), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rob_nway.md
# rob_nway

Parametrised reorder buffer for the out-of-order core. It generalises the fixed 16-entry, two-bus ROB in three ways:

- configurable depth;
- configurable count of CDB write-back channels;
- configurable data width.

It adds registered commit, misprediction flush with a redirect target, and two CDB-bypassed operand read ports. It sits between decode/rename (allocation, operand lookup) and the register file/PC logic (commit, flush).

## Interface
Parameters:
- DEPTH, 16: entry count; tags 1..DEPTH, tag 0 = "no tag / value ready".
- NUM_CDB, 2: CDB write-back channels.
- DATA_W, 32: result/target width.
- OPC_W, 12: opcode width.
- TAG_W, $clog2(DEPTH+1): tag width.

Ports (all widths follow the parameters above):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  decoder presents an instruction.
- alloc_opcode  in  OPC_W  opcode.
- alloc_rd  in  5  destination register.
- alloc_wen  in  1  instruction writes rd at commit.
- alloc_is_branch  in  1  conditional branch.
- alloc_pred_taken  in  1  predicted direction.
- alloc_alt_target  in  DATA_W  PC to redirect to on mispredict.
- alloc_ready  out  1  allocation accepted this cycle if alloc_valid.
- alloc_tag  out  TAG_W  tag given to the presented instruction (tail).
- cdb_tag  in  NUM_CDB*TAG_W  per-channel tag; 0 = idle.
- cdb_data  in  NUM_CDB*DATA_W  per-channel result.
- cdb_taken  in  NUM_CDB  per-channel branch outcome.
- rp_tag1 / rp_tag2  in  TAG_W  operand lookups.
- rp_data1 / rp_data2  out  DATA_W  looked-up value.
- rp_ready1 / rp_ready2  out  1  value valid.
- commit_valid  out  1  one-cycle commit pulse.
- commit_opcode  out  OPC_W  committed opcode.
- commit_rd  out  5  committed destination.
- commit_wen  out  1  committed write enable.
- commit_data  out  DATA_W  committed result.
- commit_tag  out  TAG_W  committed tag (register-file tag clear).
- flush  out  1  one-cycle squash pulse.
- flush_target  out  DATA_W  redirect PC.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full  out  1  full indicator.
- empty  out  1  empty indicator.

## Operation
Entry state:
- Each entry holds valid, ready, opcode, rd, wen, is_branch, pred, taken, data, alt_target.
- Head and tail run 1..DEPTH; DEPTH wraps to 1, never 0.

Allocation:
- alloc_ready = !full && !flush.
- On accept: the tail entry is written with valid=1, ready=0, then tail advances.

Write-back:
- For each channel with nonzero tag that matches a valid entry: ready=1, data and taken are written.
- Two channels hitting the same tag: lowest channel index wins.
- A tag matching no valid entry is ignored.

Commit:
- Occurs when the head entry is valid and ready. The head fields are registered onto the commit_* outputs, head advances and the entry is invalidated.
- At most one commit per cycle.

Mispredict:
- Condition: the committing entry has is_branch and taken != pred.
- On the same edge: commit_valid=1, flush=1, flush_target=alt_target, all valid bits are cleared, head=tail=1, count=0.
- Any allocation presented that cycle is discarded.

Read ports:
- Tag 0 returns ready=1, data=0.
- Otherwise the port returns the entry's stored ready/data.

Arithmetic:
- count = previous count + accept − commit; saturation is never reached.
- full = (count==DEPTH); empty = (count==0).

## Timing
Reset (rst low, asynchronous):
- Pointers = 1, count = 0, all valid cleared.
- commit_valid, flush and all other commit_* outputs = 0; flush_target = 0.
- empty = 1, full = 0.
- Reset mid-operation drops all entries with no commit pulse.

Latencies:
- Allocation to tag: alloc_tag is combinational from tail; the tag is usable by the caller in the same cycle.
- CDB to commit: result on cycle N; commit_valid rises after edge N+1 at the earliest (ready is sampled from registered state).
- Flush: flush is high for exactly one cycle, after the committing edge; alloc_ready=0 during it (one-cycle bubble).

Boundary rules:
- Full with simultaneous commit: allocation is still refused. full is computed on the current count, not the post-commit count.
- Empty with a stray CDB write: no state change.

## Configuration
- ROB_RP_CDB_BYPASS_EN defined: the read ports also compare rp_tag against the current-cycle cdb_tag. On a match they return ready=1 with the CDB data (lowest channel wins). This covers the cycle before the write lands.
- Undefined: the read ports see stored state only, so the result is visible one cycle after the CDB.

## Structure
Package rob_pkg contains:
- the entry struct;
- ROB_TAG_NULL = 0;
- the next_tag() wrap function (DEPTH→1).

Sub-module rob_read_port:
- tag lookup plus optional CDB bypass;
- instantiated twice.

## Test plan
- Allocate 3 (tags 1,2,3) → CDB tag 2 result 0x55, then tag 1 result 0x11, then tag 3 → commits occur in order 1,2,3 with data 0x11,0x55, then tag 3's result; each commit is a single-cycle commit_valid.
- DEPTH=16: allocate 16 → full=1, alloc_ready=0. Commit one → tail wraps and the next alloc_tag=1.
- Branch tag 1 with pred=0, alt_target=0x40, plus 4 younger entries; CDB taken=1 for tag 1 → commit_valid and flush both high, flush_target=0x40, count=0, next alloc_tag=1.
- Both CDB channels carry tag 5 with data 0xA and 0xB → entry 5 holds 0xA.
- With the macro defined: rp_tag1=4 while CDB tag 4 carries 0x77 → rp_ready1=1, rp_data1=0x77 in the same cycle. Without the macro, ready goes high one cycle later.
- Drive rst low mid-stream with 6 entries held → count=0, empty=1, no commit pulse, and the first allocation after reset gets tag 1.
